// File: rtl/dcache_controller.sv
// Control stage in front of a 2-way dcache SRAM: hit/miss handling, dirty-victim writeback, line refill.
// Optional hit/miss/writeback counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 4,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [TAG_W+1:0]  sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [TAG_W+1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;

  state_t           state;
  logic             req;
  logic             is_store;
  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] idx;
  logic [2:0]       word_sel;
  logic             victim_valid;
  logic             victim_dirty;
  logic [TAG_W-1:0] victim_tag;
  logic [31:0]      refill_addr;
  logic [31:0]      victim_addr;
  logic             unused_lsb;

  function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line, input logic [2:0] sel);
    return line[{sel, 5'd0} +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0] sel,
                                                   input logic [31:0] data);
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[{sel, 5'd0} +: 32] = data;
    return merged;
  endfunction

  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_store     = cpu_MemWrite_i;
  assign cpu_tag      = cpu_addr_i[31:32-TAG_W];
  assign idx          = cpu_addr_i[4+IDX_W:5];
  assign word_sel     = cpu_addr_i[4:2];
  assign unused_lsb   = ^cpu_addr_i[1:0];
  assign victim_valid = sram_tag_i[TAG_W+1];
  assign victim_dirty = sram_tag_i[TAG_W];
  assign victim_tag   = sram_tag_i[TAG_W-1:0];
  assign refill_addr  = {cpu_tag, idx, 5'd0};
  assign victim_addr  = {victim_tag, idx, 5'd0};

  assign sram_addr_o  = idx;
  assign cpu_data_o   = word_of(sram_data_i, word_sel);

  always_comb begin
    cpu_stall_o   = 1'b1;
    sram_enable_o = req;
    sram_write_o  = 1'b0;
    sram_tag_o    = '0;
    sram_data_o   = sram_data_i;
    case (state)
      IDLE: begin
        cpu_stall_o = req & ~sram_hit_i;
        if (is_store & sram_hit_i) begin
          sram_write_o = 1'b1;
          sram_tag_o   = {1'b1, 1'b1, cpu_tag};
          sram_data_o  = merge_word(sram_data_i, word_sel, cpu_data_i);
        end
      end
      READMISS: begin
        // Refill lands in the LRU way the SRAM is pointing at; the line is clean.
        if (mem_ack_i) begin
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_tag_o    = {1'b1, 1'b0, cpu_tag};
          sram_data_o   = mem_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      mem_enable_o <= 1'b0;
      case (state)
        IDLE: if (req & ~sram_hit_i) state <= MISS;
        MISS: begin
          mem_enable_o <= 1'b1;
          if (victim_valid & victim_dirty) begin
            state       <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= victim_addr;
            mem_data_o  <= sram_data_i;
          end else begin
            state       <= READMISS;
            mem_write_o <= 1'b0;
            mem_addr_o  <= refill_addr;
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          mem_enable_o <= 1'b1;
          mem_write_o  <= 1'b0;
          mem_addr_o   <= refill_addr;
          state        <= READMISS;
        end
        READMISS:   if (mem_ack_i) state <= READMISSOK;
        READMISSOK: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_refill;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The first IDLE cycle after a refill re-evaluates the held request; it is not a new hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      after_refill <= 1'b0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
      wb_cnt_o     <= '0;
    end else begin
      after_refill <= (state == READMISSOK);
      if (state == IDLE && req && sram_hit_i && !after_refill) hit_cnt_o <= sat_inc(hit_cnt_o);
      if (state == IDLE && req && !sram_hit_i)                 miss_cnt_o <= sat_inc(miss_cnt_o);
      if (state == MISS && victim_valid && victim_dirty)       wb_cnt_o <= sat_inc(wb_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: emulated 2-way SRAM and latency memory, plus a cache-transparency reference model.
`timescale 1ns/1ps
module tb_dcache_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rd, wr;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         stall;
  logic [3:0]   sram_addr;
  logic [24:0]  sram_tag_w, sram_tag_r;
  logic [255:0] sram_wline, sram_rline;
  logic         sram_en, sram_we, sram_hit;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wline, mem_rline;
  logic         mem_en, mem_we, mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr), .cpu_data_o(cpu_rdata), .cpu_stall_o(stall),
    .sram_addr_o(sram_addr), .sram_tag_o(sram_tag_w), .sram_data_o(sram_wline),
    .sram_enable_o(sram_en), .sram_write_o(sram_we), .sram_tag_i(sram_tag_r),
    .sram_data_i(sram_rline), .sram_hit_i(sram_hit), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wline), .mem_enable_o(mem_en), .mem_write_o(mem_we),
    .mem_data_i(mem_rline), .mem_ack_i(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Emulated SRAM: 16 sets x 2 ways, one LRU pointer per set.
  logic         s_vld [16][2];
  logic         s_dty [16][2];
  logic [22:0]  s_tag [16][2];
  logic [255:0] s_dat [16][2];
  logic         s_lru [16];
  logic         hw;

  always_comb begin
    sram_hit = 1'b0;
    hw       = s_lru[cpu_addr[8:5]];
    for (int w = 0; w < 2; w++)
      if (s_vld[cpu_addr[8:5]][w] && s_tag[cpu_addr[8:5]][w] == cpu_addr[31:9]) begin
        sram_hit = 1'b1;
        hw       = w[0];
      end
    sram_tag_r = {s_vld[cpu_addr[8:5]][hw], s_dty[cpu_addr[8:5]][hw], s_tag[cpu_addr[8:5]][hw]};
    sram_rline = s_dat[cpu_addr[8:5]][hw];
  end

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        s_vld[sram_addr][hw] <= sram_tag_w[24];
        s_dty[sram_addr][hw] <= sram_tag_w[23];
        s_tag[sram_addr][hw] <= sram_tag_w[22:0];
        s_dat[sram_addr][hw] <= sram_wline;
        s_lru[sram_addr]     <= ~hw;
      end else if (sram_hit) begin
        s_lru[sram_addr] <= ~hw;
      end
    end
  end

  // Backing memory with per-transaction latency.
  logic [255:0] mem_store [logic [31:0]];
  typedef struct packed {logic we; logic [31:0] addr; logic [255:0] data;} txn_t;
  txn_t plog[$];
  int lat = 10;
  int cnt = 0;
  txn_t pend;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(4 * i));
    return l;
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rline = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_ack = 1'b1;
          if (pend.we) mem_store[pend.addr] = pend.data;
          else         mem_rline = mem_line(pend.addr);
        end
      end
      if (mem_en) begin
        pend.we = mem_we; pend.addr = mem_addr; pend.data = mem_wline;
        plog.push_back(pend);
        cnt = lat;
      end
    end
  end

  // Reference model: what a transparent cache must return, and the LRU occupancy of each set.
  logic [31:0] ref_mem [logic [31:0]];
  typedef struct packed {logic [22:0] tag; logic dirty;} ent_t;
  ent_t cset [16][$];
  int m_hits = 0, m_miss = 0, m_wb = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_word(la + 32'(4 * i));
    return l;
  endfunction

  logic prev_men = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check("sram_addr", 256'(sram_addr), 256'(cpu_addr[8:5]));
      if (!sram_we) check("sram_enable", 256'(sram_en), 256'(rd | wr));
      if (mem_en) check("mem_en_pulse", 256'(prev_men), 256'(0));
    end
    prev_men <= mem_en;
  end

  task automatic do_req(input logic rdq, input logic wrq, input logic [31:0] addr,
                        input logic [31:0] data, output int stalls, output logic [31:0] rdata);
    logic [3:0]   ix;
    logic [22:0]  tg;
    logic [31:0]  wa, la, wb_addr;
    logic [255:0] wb_line, exp_line;
    logic         exp_hit, exp_wb;
    int           pos, refills, exp_stalls, npulse;
    ent_t         e;
    ix = addr[8:5]; tg = addr[31:9]; wa = {addr[31:2], 2'b00}; la = {tg, ix, 5'd0};
    pos = -1;
    for (int k = 0; k < cset[ix].size(); k++) if (cset[ix][k].tag == tg) pos = k;
    exp_hit = (pos >= 0);
    exp_wb  = 1'b0;
    wb_addr = '0; wb_line = '0;
    if (!exp_hit && cset[ix].size() == 2) begin
      exp_wb  = cset[ix][1].dirty;
      wb_addr = {cset[ix][1].tag, ix, 5'd0};
      wb_line = ref_line(wb_addr);
    end
    exp_stalls = exp_hit ? 0 : (exp_wb ? 5 + 2 * lat : 4 + lat);
    npulse     = exp_hit ? 0 : (exp_wb ? 2 : 1);
    plog.delete();
    cpu_addr = addr; cpu_wdata = data; rd = rdq; wr = wrq;
    stalls = 0; refills = 0;
    @(negedge clk);
    check("stall_first", 256'(stall), 256'(!exp_hit));
    while (stall && stalls < 300) begin
      if (sram_we) begin
        refills++;
        check("refill_tag", 256'(sram_tag_w), 256'({2'b10, tg}));
        check("refill_line", sram_wline, ref_line(la));
      end
      stalls++;
      @(negedge clk);
    end
    if (stall) check("stall_timeout", 256'(stall), 256'(0));
    check("stall_cycles", 256'(stalls), 256'(exp_stalls));
    check("refill_writes", 256'(refills), 256'(exp_hit ? 0 : 1));
    check("pulse_count", 256'(plog.size()), 256'(npulse));
    if (plog.size() == npulse && npulse > 0) begin
      if (exp_wb) begin
        check("wb_write", 256'(plog[0].we), 256'(1));
        check("wb_addr", 256'(plog[0].addr), 256'(wb_addr));
        check("wb_data", plog[0].data, wb_line);
      end
      check("rd_write", 256'(plog[npulse-1].we), 256'(0));
      check("rd_addr", 256'(plog[npulse-1].addr), 256'(la));
    end
    rdata = cpu_rdata;
    if (wrq) begin
      exp_line = ref_line(la);
      exp_line[addr[4:2]*32 +: 32] = data;
      check("store_we", 256'(sram_we), 256'(1));
      check("store_tag", 256'(sram_tag_w), 256'({2'b11, tg}));
      check("store_line", sram_wline, exp_line);
      ref_mem[wa] = data;
    end else begin
      check("load_we", 256'(sram_we), 256'(0));
      check("load_data", 256'(cpu_rdata), 256'(ref_word(wa)));
    end
    if (exp_hit) begin
      m_hits++;
      e = cset[ix][pos];
      e.dirty = e.dirty | wrq;
      cset[ix].delete(pos);
    end else begin
      m_miss++;
      if (exp_wb) m_wb++;
      if (cset[ix].size() == 2) void'(cset[ix].pop_back());
      e.tag = tg; e.dirty = wrq;
    end
    cset[ix].push_front(e);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int st, acks, late_w;
    logic [31:0] rdat, a;
    logic [22:0] tgs [5];
    logic [3:0]  ixs [3];
    for (int s = 0; s < 16; s++) begin
      s_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        s_vld[s][w] = 1'b0; s_dty[s][w] = 1'b0; s_tag[s][w] = '0; s_dat[s][w] = '0;
      end
    end
    rst = 1'b1; rd = 1'b0; wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 256'(mem_en), 256'(0));
    check("rst_mem_we", 256'(mem_we), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_mem_data", mem_wline, 256'(0));
    check("rst_stall", 256'(stall), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold load, store hit, load back.
    lat = 10;
    do_req(1'b1, 1'b0, 32'h0000_0124, 32'h0, st, rdat);
    check("cold_stalls", 256'(st), 256'(14));
    check("cold_rd_addr", 256'(plog.size() == 1 ? plog[0].addr : 32'hFFFF_FFFF), 256'(32'h0000_0120));
    check("cold_tag", 256'({s_vld[9][0], s_dty[9][0], s_tag[9][0]}), 256'(25'h100_0000));
    check("cold_data", 256'(rdat), 256'(32'h786A_134B));
    do_req(1'b0, 1'b1, 32'h0000_0124, 32'hDEAD_BEEF, st, rdat);
    check("store_hit_stalls", 256'(st), 256'(0));
    check("store_hit_tag", 256'({s_vld[9][0], s_dty[9][0], s_tag[9][0]}), 256'(25'h180_0000));
    do_req(1'b1, 1'b0, 32'h0000_0124, 32'h0, st, rdat);
    check("load_back", 256'(rdat), 256'(32'hDEAD_BEEF));

    // Dirty eviction of the LRU way.
    do_req(1'b0, 1'b1, 32'h0000_2124, 32'h1111_2222, st, rdat);
    do_req(1'b1, 1'b0, 32'h0000_4124, 32'h0, st, rdat);
    check("dirty_stalls", 256'(st), 256'(25));
    check("dirty_pulses", 256'(plog.size()), 256'(2));
    if (plog.size() == 2) begin
      check("dirty_wb_addr", 256'(plog[0].addr), 256'(32'h0000_0120));
      check("dirty_wb_word", 256'(plog[0].data[63:32]), 256'(32'hDEAD_BEEF));
      check("dirty_rd_addr", 256'(plog[1].addr), 256'(32'h0000_4120));
    end

    // Clean eviction: no writeback.
    do_req(1'b1, 1'b0, 32'h0000_2124, 32'h0, st, rdat);
    check("clean_hit_data", 256'(rdat), 256'(32'h1111_2222));
    do_req(1'b1, 1'b0, 32'h0000_6124, 32'h0, st, rdat);
    check("clean_stalls", 256'(st), 256'(14));
    check("clean_rd_addr", 256'(plog.size() == 1 ? plog[0].addr : 32'hFFFF_FFFF), 256'(32'h0000_6120));

    // Reset while the refill is outstanding.
    plog.delete();
    cpu_addr = 32'h0000_8064; rd = 1'b1;
    for (int i = 0; i < 50 && plog.size() == 0; i++) @(negedge clk);
    check("abort_pulse", 256'(plog.size()), 256'(1));
    m_miss++;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; rd = 1'b0;
    @(negedge clk);
    check("abort_stall", 256'(stall), 256'(0));
    check("abort_mem_en", 256'(mem_en), 256'(0));
    acks = 0; late_w = 0;
    repeat (15) begin
      @(negedge clk);
      if (sram_we) late_w++;
      if (mem_ack) acks++;
    end
    check("abort_late_ack", 256'(acks), 256'(1));
    check("abort_no_write", 256'(late_w), 256'(0));
    check("abort_no_pulse", 256'(plog.size()), 256'(1));
    @(posedge clk); #1;

    // Randomized traffic over a few conflicting tags in three sets.
    tgs = '{23'h0, 23'h10, 23'h20, 23'h30, 23'h40};
    ixs = '{4'd9, 4'd3, 4'd0};
    for (int n = 0; n < 400; n++) begin
      int mode;
      lat  = int'($urandom_range(1, 12));
      a    = {tgs[$urandom % 5], ixs[$urandom % 3], 3'($urandom), 2'b00};
      mode = int'($urandom % 4);
      do_req(mode != 2, mode >= 2, a, $urandom, st, rdat);
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check("hit_cnt", 256'(hit_cnt), 256'(m_hits));
    check("miss_cnt", 256'(miss_cnt), 256'(m_miss));
    check("wb_cnt", 256'(wb_cnt), 256'(m_wb));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Control stage directly upstream of the 2-way dcache SRAM (16 sets × 2 ways, 256-bit lines, 25-bit tag entry {valid, dirty, tag[22:0]}).
- Accepts 32-bit CPU loads and stores, and detects hit or miss using the SRAM's hit flag.
- Drives line writes into the SRAM, performs dirty-victim writeback and line refill against a 256-bit data memory, and stalls the CPU while a miss is serviced.

Parameters:
- TAG_W, 23: tag bits, taken from cpu_addr_i[31:9].
- IDX_W, 4: set index bits, taken from cpu_addr_i[8:5].
- LINE_W, 256: cache line width; byte offset is cpu_addr_i[4:0], word select is cpu_addr_i[4:2].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold its request
- sram_addr_o  out  IDX_W  set index
- sram_tag_o  out  25  {valid, dirty, tag} to write
- sram_data_o  out  LINE_W  line to write
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  hit way's tag, or LRU victim tag on miss
- sram_data_i  in  LINE_W  hit way's line, or LRU victim line on miss
- sram_hit_i  in  1  tag match in a valid way
- mem_addr_o  out  32  line-aligned memory address
- mem_data_o  out  LINE_W  writeback line
- mem_enable_o  out  1  one-cycle transaction start pulse
- mem_write_o  out  1  1 = writeback, 0 = refill read
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  one-cycle transaction done

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset state:
  - state = IDLE.
  - mem_enable_o, mem_write_o = 0; mem_addr_o, mem_data_o = 0.
  - cpu_stall_o follows its combinational rule (0 with no request).
- Request: req = cpu_MemRead_i | cpu_MemWrite_i. If both are high, treat as a store.
- sram_addr_o = cpu_addr_i[8:5] at all times; sram_enable_o = req.
- State machine: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
- cpu_stall_o (combinational):
  - In IDLE: req & ~sram_hit_i.
  - In every other state: 1.
- IDLE, read hit:
  - cpu_data_o = sram_data_i word selected by cpu_addr_i[4:2], in the same cycle (zero-latency hit).
- IDLE, write hit:
  - sram_write_o = 1.
  - sram_data_o = sram_data_i with the selected word replaced by cpu_data_i.
  - sram_tag_o = {1, 1, cpu tag}.
- IDLE, miss (req & ~hit): next state = MISS.
- MISS: sample the victim entry sram_tag_i.
  - If valid & dirty: next state = WRITEBACK. Pulse mem_enable_o, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = sram_data_i.
  - Otherwise: next state = READMISS. Pulse mem_enable_o, mem_write_o = 0, mem_addr_o = {cpu tag, index, 5'b0}.
- WRITEBACK:
  - Hold mem_addr_o, mem_data_o and mem_write_o stable.
  - On mem_ack_i: pulse mem_enable_o with mem_write_o = 0 and the refill address, then go to READMISS.
- READMISS:
  - On mem_ack_i: sram_enable_o = 1, sram_write_o = 1, sram_tag_o = {1, 0, cpu tag}, sram_data_o = mem_data_i.
  - Next state = READMISSOK.
- READMISSOK: next state = IDLE. The held request is re-evaluated there and hits, so loads return data and stores merge as write hits.
- mem_enable_o is exactly one cycle per transaction. mem_ack_i outside WRITEBACK or READMISS is ignored.
- Reset mid-miss: return to IDLE on the next edge; any outstanding memory ack is dropped.
- Request deasserted while stalled: protocol violation. The FSM still completes the refill.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0], miss_cnt_o[31:0] and wb_cnt_o[31:0].
  - All counters reset to 0 and saturate at 32'hFFFFFFFF.
  - hit_cnt_o increments on each IDLE cycle with req & hit. Misses are not re-counted as hits after refill.
  - miss_cnt_o increments on the IDLE→MISS transition.
  - wb_cnt_o increments on the MISS→WRITEBACK transition.
- Undefined: no counter ports and no counter logic.

Test Plan:
- Cold load: after reset, bench memory latency 10 cycles, load 0x0000_0124 (index 9, word 1) → one mem read pulse at addr 0x0000_0120; stall for the full miss; SRAM written with tag {1, 0, 0}; cpu_data_o = word 1 of the refill line.
- Store hit: after the cold load, store 0xDEADBEEF to 0x0000_0124 → no stall, sram_write_o = 1, dirty bit set, next load returns 0xDEADBEEF.
- Dirty eviction: fill both ways of index 9 with dirty lines, then load 0x0000_4124 → writeback pulse (mem_write_o = 1) at the LRU victim address, then a refill pulse at 0x0000_4120; stall until READMISSOK.
- Clean eviction: victim valid but not dirty → no writeback pulse, refill only.
- Reset during READMISS: assert rst_i before mem_ack_i → state returns to IDLE, mem_enable_o = 0, a late ack causes no SRAM write.
- DCACHE_STATS_EN: 1 cold miss + 3 hits + 1 dirty eviction → hit_cnt_o = 3, miss_cnt_o = 2, wb_cnt_o = 1.
